cp0_exc_unit: RTL and testbench

Parametrised CP0 register file and exception/interrupt controller for the single-cycle CPU. It sits beside the instruction decoder and holds status, cause and epc. It latches NUM_IRQ interrupt lines with per-line masks and prioritises synchronous exceptions over interrupts. It keeps a bounded status stack so that handlers can be nested, and it supplies the redirect PC, the mfc0 read data and a one-hot interrupt acknowledge.

---
 rtl/cp0_pkg.sv | 30 +++
 rtl/cp0_status_stack.sv | 50 +++++
 rtl/cp0_exc_unit.sv | 144 ++++++++++++++
 tb/tb_cp0_exc_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 shared constants: register indices, exception codes,
// status/cause bit positions and the redirect-PC select encodings.
package cp0_pkg;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam logic [1:0] EXC_INTR   = 2'd0;
    localparam logic [1:0] EXC_SYS    = 2'd1;
    localparam logic [1:0] EXC_UNIMPL = 2'd2;
    localparam logic [1:0] EXC_OVF    = 2'd3;

    localparam int STA_IE  = 0;
    localparam int STA_SYS = 1;
    localparam int STA_UNI = 2;
    localparam int STA_OVF = 3;
    localparam int STA_IM  = 8;

    localparam int CAU_CODE = 2;
    localparam int CAU_PEND = 8;
    localparam int CAU_IDX  = 16;

    typedef enum logic [1:0] {
        SEL_NPC = 2'b00,
        SEL_EPC = 2'b01,
        SEL_VEC = 2'b10
    } selpc_e;

endpackage

// File: rtl/cp0_status_stack.sv
// Bounded LIFO of saved status words for nested traps.
// Ports: clk, clrn (sync, active-low), push, pop, din -> top, full, empty.
module cp0_status_stack
    import cp0_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] top,
    output logic        full,
    output logic        empty
);

    logic [31:0]   stk [DEPTH];
    logic [DW-1:0] depth;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (depth == DW'(i + 1)) top = stk[i];
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            depth <= '0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (push) begin
            if (full) begin
                // Overflow: discard the oldest entry, depth saturates.
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i + 1];
                stk[DEPTH - 1] <= din;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (depth == DW'(i)) stk[i] <= din;
                depth <= depth + DW'(1);
            end
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 status/cause/epc registers with trap prioritisation, IRQ masking
// and nested-handler status stack. Inputs: retire strobe, pc/npc,
// exception flags, eret, mtc0/c0 index/data, irq lines. Outputs:
// c0_rdata, exc, selpc, exc_vector, epc_out, sta_out, inta.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter int          NEST_DEPTH = 2,
    parameter bit          IRQ_EDGE   = 1'b0,
    parameter bit          VECTORED   = 1'b0,
    parameter logic [31:0] EXC_BASE   = 32'h0000_0008
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               valid,
    input  logic [31:0]        pc,
    input  logic [31:0]        npc,
    input  logic               syscall,
    input  logic               unimpl,
    input  logic               ovf,
    input  logic               eret,
    input  logic               mtc0,
    input  logic [4:0]         c0_rd,
    input  logic [31:0]        c0_wdata,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        c0_rdata,
    output logic               exc,
    output logic [1:0]         selpc,
    output logic [31:0]        exc_vector,
    output logic [31:0]        epc_out,
    output logic [31:0]        sta_out,
    output logic [NUM_IRQ-1:0] inta
);

    localparam logic [31:0] STA_MASK =
        32'h0000_000F | (((32'd1 << NUM_IRQ) - 32'd1) << STA_IM);

    logic [31:0]        sta, epc, cause_rd, stk_top;
    logic [1:0]         code, code_n;
    logic [2:0]         idx, id;
    logic [NUM_IRQ-1:0] pend, pend_q, irq_q, elig, clr;
    logic               take, sync, int_ok, is_int;
    logic               do_wr, do_pop, stk_full, stk_empty;

    assign pend = IRQ_EDGE ? pend_q : irq;
    assign elig = pend & sta[STA_IM +: NUM_IRQ];
    assign take = clrn & valid;

    always_comb begin
        sync   = 1'b1;
        code_n = EXC_INTR;
        if (ovf && sta[STA_OVF])         code_n = EXC_OVF;
        else if (unimpl && sta[STA_UNI]) code_n = EXC_UNIMPL;
        else if (syscall && sta[STA_SYS]) code_n = EXC_SYS;
        else                              sync = 1'b0;
    end

    always_comb begin
        id = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (elig[k]) id = 3'(k);
    end

    // Interrupts are deferred while the stack is full or CP0 is busy.
    assign int_ok = sta[STA_IE] & (|elig) & ~stk_full & ~mtc0 & ~eret;
    assign exc    = take & (sync | int_ok);
    assign is_int = exc & ~sync;
    assign inta   = is_int ? (NUM_IRQ'(1) << id) : '0;
    assign do_wr  = take & mtc0 & ~exc;
    assign do_pop = take & eret & ~exc;

    assign exc_vector = (VECTORED && is_int)
                      ? EXC_BASE + 32'({id, 5'b0}) + 32'd32
                      : EXC_BASE;

    always_comb begin
        selpc = SEL_NPC;
        if (exc)         selpc = SEL_VEC;
        else if (do_pop) selpc = SEL_EPC;
    end

    always_comb begin
        cause_rd = '0;
        cause_rd[CAU_CODE +: 2]       = code;
        cause_rd[CAU_PEND +: NUM_IRQ] = pend;
        cause_rd[CAU_IDX +: 3]        = idx;
    end

    always_comb begin
        unique case (c0_rd)
            REG_STATUS: c0_rdata = sta;
            REG_CAUSE:  c0_rdata = cause_rd;
            REG_EPC:    c0_rdata = epc;
            default:    c0_rdata = '0;
        endcase
    end

    always_comb begin
        clr = inta;
        if (do_wr && c0_rd == REG_CAUSE)
            clr = clr | ~c0_wdata[CAU_PEND +: NUM_IRQ];
    end

    assign epc_out = epc;
    assign sta_out = sta;

    cp0_status_stack #(.DEPTH(NEST_DEPTH)) u_stack (
        .clk   (clk),
        .clrn  (clrn),
        .push  (exc),
        .pop   (do_pop),
        .din   (sta),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            sta    <= '0;
            epc    <= '0;
            code   <= '0;
            idx    <= '0;
            pend_q <= '0;
            irq_q  <= '0;
        end else if (valid) begin
            if (exc) begin
                epc  <= sync ? pc : npc;
                sta  <= sta & ~32'd1;
                code <= code_n;
                if (is_int) idx <= id;
            end else begin
                if (do_wr && c0_rd == REG_STATUS) sta <= c0_wdata & STA_MASK;
                if (do_wr && c0_rd == REG_EPC)    epc <= c0_wdata;
                // eret wins over a simultaneous status write.
                if (do_pop && !stk_empty)         sta <= stk_top & STA_MASK;
            end
            irq_q  <= irq;
            pend_q <= (pend_q & ~clr) | (irq & ~irq_q);
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench: a level/direct and an edge/vectored instance share
// stimulus; a behavioural model predicts each cycle's outputs.
module tb_cp0_exc_unit;

    localparam logic [31:0] BASE = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        clrn, valid, syscall, unimpl, ovf, eret, mtc0;
    logic [31:0] pc, npc, c0_wdata;
    logic [4:0]  c0_rd;
    logic [3:0]  irq;

    logic [31:0] d_rdata [2], d_vec [2], d_epc [2], d_sta [2];
    logic        d_exc   [2];
    logic [1:0]  d_selpc [2];
    logic [3:0]  d_inta  [2];

    always #5 clk = ~clk;

    cp0_exc_unit #(.IRQ_EDGE(1'b0), .VECTORED(1'b0)) u0 (
        .clk(clk), .clrn(clrn), .valid(valid), .pc(pc), .npc(npc),
        .syscall(syscall), .unimpl(unimpl), .ovf(ovf), .eret(eret),
        .mtc0(mtc0), .c0_rd(c0_rd), .c0_wdata(c0_wdata), .irq(irq),
        .c0_rdata(d_rdata[0]), .exc(d_exc[0]), .selpc(d_selpc[0]),
        .exc_vector(d_vec[0]), .epc_out(d_epc[0]), .sta_out(d_sta[0]),
        .inta(d_inta[0])
    );

    cp0_exc_unit #(.IRQ_EDGE(1'b1), .VECTORED(1'b1)) u1 (
        .clk(clk), .clrn(clrn), .valid(valid), .pc(pc), .npc(npc),
        .syscall(syscall), .unimpl(unimpl), .ovf(ovf), .eret(eret),
        .mtc0(mtc0), .c0_rd(c0_rd), .c0_wdata(c0_wdata), .irq(irq),
        .c0_rdata(d_rdata[1]), .exc(d_exc[1]), .selpc(d_selpc[1]),
        .exc_vector(d_vec[1]), .epc_out(d_epc[1]), .sta_out(d_sta[1]),
        .inta(d_inta[1])
    );

    typedef struct {
        logic        exc;
        logic [1:0]  selpc;
        logic [31:0] vec;
        logic [3:0]  inta;
        logic [31:0] rdata;
        logic [31:0] epc;
        logic [31:0] sta;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_sta [2], m_epc [2];
    logic [1:0]  m_code [2];
    logic [2:0]  m_idx [2];
    logic [3:0]  m_pend [2], m_prev [2];
    logic [31:0] m_stk [2][$];

    task automatic model_reset(int u);
        m_sta[u] = 0; m_epc[u] = 0; m_code[u] = 0; m_idx[u] = 0;
        m_pend[u] = 0; m_prev[u] = 0;
        m_stk[u].delete();
    endtask

    task automatic model(int u);
        exp_t        e;
        bit          edge_m = (u == 1);
        logic [3:0]  pend, hit, clr;
        int          scode, intk;
        bit          take, trap;
        pend  = edge_m ? m_pend[u] : irq;
        hit   = pend & m_sta[u][11:8];
        scode = -1;
        if (ovf && m_sta[u][3])          scode = 3;
        else if (unimpl && m_sta[u][2])  scode = 2;
        else if (syscall && m_sta[u][1]) scode = 1;
        intk = -1;
        if (scode < 0 && m_sta[u][0] && !mtc0 && !eret && m_stk[u].size() < 2)
            for (int k = 3; k >= 0; k--) if (hit[k]) intk = k;
        take = clrn && valid;
        trap = take && (scode >= 0 || intk >= 0);
        e.exc   = trap;
        e.inta  = (trap && scode < 0) ? 4'(1 << intk) : 4'd0;
        e.vec   = (trap && scode < 0 && edge_m) ? BASE + 32 * (intk + 1) : BASE;
        e.selpc = trap ? 2'b10 : (take && eret) ? 2'b01 : 2'b00;
        case (c0_rd)
            5'd12:   e.rdata = m_sta[u];
            5'd13:   e.rdata = (32'(m_idx[u]) << 16) | (32'(pend) << 8)
                             | (32'(m_code[u]) << 2);
            5'd14:   e.rdata = m_epc[u];
            default: e.rdata = 0;
        endcase
        e.epc = m_epc[u];
        e.sta = m_sta[u];
        q.push_back(e);

        if (!clrn) begin
            model_reset(u);
        end else if (valid) begin
            clr = 0;
            if (trap) begin
                m_stk[u].push_back(m_sta[u]);
                if (m_stk[u].size() > 2) void'(m_stk[u].pop_front());
                m_sta[u][0] = 1'b0;
                if (scode >= 0) begin
                    m_epc[u]  = pc;
                    m_code[u] = 2'(scode);
                end else begin
                    m_epc[u]  = npc;
                    m_code[u] = 0;
                    m_idx[u]  = 3'(intk);
                    clr       = e.inta;
                end
            end else begin
                if (mtc0 && c0_rd == 12) m_sta[u] = c0_wdata & 32'h0000_0F0F;
                if (mtc0 && c0_rd == 14) m_epc[u] = c0_wdata;
                if (mtc0 && c0_rd == 13) clr = ~c0_wdata[11:8];
                if (eret && m_stk[u].size() > 0) m_sta[u] = m_stk[u].pop_back();
            end
            m_pend[u] = (m_pend[u] & ~clr) | (irq & ~m_prev[u]);
            m_prev[u] = irq;
        end
    endtask

    task automatic step();
        model(0);
        model(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clrn = 1; valid = 1; syscall = 0; unimpl = 0; ovf = 0;
        eret = 0; mtc0 = 0; c0_rd = 5'd12; c0_wdata = 0;
        pc = pc + 4; npc = pc + 4;
    endtask

    task automatic chk(string name, int u, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got %h expected %h",
                     name, u, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() >= 2) begin
            for (int u = 0; u < 2; u++) begin
                e = q.pop_front();
                chk("exc",   u, 32'(d_exc[u]),   32'(e.exc));
                chk("selpc", u, 32'(d_selpc[u]), 32'(e.selpc));
                chk("vec",   u, d_vec[u],        e.vec);
                chk("inta",  u, 32'(d_inta[u]),  32'(e.inta));
                chk("rdata", u, d_rdata[u],      e.rdata);
                chk("epc",   u, d_epc[u],        e.epc);
                chk("sta",   u, d_sta[u],        e.sta);
            end
        end
    end

    initial begin
        model_reset(0);
        model_reset(1);
        pc = 32'h0000_1000;
        idle();
        irq = 0;
        clrn = 0;
        @(posedge clk);
        #1;
        // reset, reading every register
        clrn = 0; c0_rd = 12; step();
        idle(); c0_rd = 13; step();
        idle(); c0_rd = 14; step();
        // status write then read back
        idle(); mtc0 = 1; c0_rd = 12; c0_wdata = 32'hFFFF_FFFF; step();
        idle(); step();
        // overflow beats a simultaneous irq[0]
        idle(); ovf = 1; irq = 4'b0001; c0_rd = 13; step();
        idle(); c0_rd = 13; step();
        idle(); eret = 1; step();
        // first interrupt (u0 level) and edge pulse on irq[2] for u1
        idle(); irq = 4'b0100; step();
        idle(); irq = 4'b0000; c0_rd = 13; step();
        // re-enable IE (blocks interrupt this cycle), then nest
        idle(); mtc0 = 1; c0_wdata = 32'h0000_0F0F; irq = 4'b0010; step();
        idle(); step();
        idle(); mtc0 = 1; c0_wdata = 32'h0000_0F0F; step();
        idle(); step();
        idle(); step();
        idle(); eret = 1; step();
        idle(); eret = 1; step();
        idle(); eret = 1; step();
        // reset in the middle of a handler
        idle(); irq = 4'b1000; mtc0 = 1; c0_wdata = 32'h0000_0F0F; step();
        idle(); step();
        idle(); clrn = 0; c0_rd = 14; step();
        idle(); irq = 0; eret = 1; step();
        idle(); c0_rd = 13; step();
        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            idle();
            clrn     = ($urandom_range(0, 99) != 0);
            valid    = ($urandom_range(0, 9) != 0);
            pc       = $urandom & 32'hFFFF_FFFC;
            npc      = pc + 4;
            ovf      = ($urandom_range(0, 19) == 0);
            unimpl   = ($urandom_range(0, 19) == 0);
            syscall  = ($urandom_range(0, 14) == 0);
            eret     = ($urandom_range(0, 7) == 0);
            mtc0     = ($urandom_range(0, 5) == 0);
            c0_rd    = 5'($urandom_range(11, 15));
            c0_wdata = $urandom;
            if ($urandom_range(0, 1) == 0) c0_wdata[0] = 1'b1;
            if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
